axis_gmii_rx_lenchk: RTL
========================

# axis_gmii_rx_lenchk

Byte-wide GMII-to-AXI4-Stream frame receiver with frame-length policing. It detects the SFD, strips the preamble, SFD and FCS, checks the CRC-32 FCS, and enforces configurable minimum and maximum frame lengths. It reports per-frame length and error status. It sits between the PHY-side GMII interface and the MAC RX FIFO; the output has no backpressure.

## Interface
- MIN_FRAME_LEN, 64: minimum legal length in bytes, counted from the first byte after SFD through the last FCS byte.
- MAX_FRAME_LEN, 1518: maximum legal length, counted the same way.
- LEN_WIDTH, 16: width of frame_len; must satisfy 2^LEN_WIDTH > MAX_FRAME_LEN+1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- gmii_rxd  in  8  receive data.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rx_er  in  1  receive error.
- clk_enable  in  1  qualifies each clk cycle; logic advances only when high.
- cfg_rx_enable  in  1  accept new frames; sampled only in IDLE.
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  byte valid; no tready.
- m_axis_tlast  out  1  last byte of frame.
- m_axis_tuser  out  1  bad frame; valid with tlast.
- start_packet  out  1  one-cycle pulse when SFD is seen at the input stage.
- error_bad_frame  out  1  pulse: frame ended with tuser=1.
- error_bad_fcs  out  1  pulse: FCS mismatch.
- error_runt  out  1  pulse: length < MIN_FRAME_LEN.
- error_oversize  out  1  pulse: frame truncated at MAX_FRAME_LEN.
- frame_len  out  LEN_WIDTH  length of the last terminated frame.
- frame_len_valid  out  1  pulse: frame_len updated.

## Operation
- Input pipeline: gmii_rxd, gmii_rx_dv and gmii_rx_er pass through a 5-stage shift register d0..d4, advanced on enabled cycles.
  - dv_dN is stage dv ANDed with the live gmii_rx_dv.
  - d0..d3 hold the FCS window; d4 feeds the CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF).
- IDLE:
  - CRC reset; byte counter cleared.
  - Go to PAYLOAD when dv_d4 && !er_d4 && d4==0xD5 && cfg_rx_enable.
- PAYLOAD, per enabled cycle, in priority order:
  1. er_d4 && dv_d4: emit d4 with tlast=1, tuser=1; pulse error_bad_frame; frame_len = count+1; go to WAIT_LAST.
  2. !gmii_rx_dv: emit d4 with tlast=1; frame_len = count+1+4.
     - tuser=1 if any of er_d0..er_d3, FCS mismatch (~crc_next != {d0,d1,d2,d3}), or frame_len < MIN_FRAME_LEN.
     - Pulse the matching error_bad_fcs / error_runt (both may assert); pulse error_bad_frame if tuser=1.
     - Go to IDLE.
  3. count+1+4 > MAX_FRAME_LEN: emit d4 with tlast=1, tuser=1; pulse error_oversize and error_bad_frame; frame_len = MAX_FRAME_LEN+1; go to WAIT_LAST.
  4. Otherwise: emit d4, update CRC, count++.
- WAIT_LAST: emit nothing; go to IDLE when !gmii_rx_dv.
- frame_len_valid pulses on every tlast.
- cfg_rx_enable falling mid-frame has no effect on the current frame.
- Back-to-back frames with a 1-cycle dv gap are received correctly.

## Timing
- Latency: a byte on gmii_rxd at enabled cycle t appears on m_axis_tdata at enabled cycle t+6.
- tvalid is high for exactly one cycle per byte.
- On any cycle with clk_enable=0:
  - tvalid, tlast, tuser and all pulses are 0;
  - the pipeline, state, CRC and counter hold.
- start_packet asserts two cycles after the SFD is registered into d0.
- All error pulses and frame_len_valid coincide with the tlast cycle.
- Reset values:
  - all outputs 0; frame_len 0;
  - state IDLE; dv_d0..d4 = 0;
  - CRC 0xFFFFFFFF.
- rst mid-frame: the next cycle is IDLE with no tlast emitted for the aborted frame; the following frame is received normally.

## Configuration
- GMII_RX_STATS_EN defined:
  - adds outputs stat_frames_good [31:0] and stat_frames_bad [31:0];
  - each increments on a tlast with tuser=0 or tuser=1 respectively;
  - counters saturate at 0xFFFFFFFF and reset to 0.
- GMII_RX_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Good 64-byte frame (7×0x55, 0xD5, 60 payload bytes, correct FCS) -> 60 tvalid beats; tlast on byte 60 with tuser=0; frame_len=64; no error pulses.
- Same frame with one FCS byte corrupted -> tuser=1; error_bad_fcs=1; error_bad_frame=1; frame_len=64.
- 40-byte frame with valid FCS -> 36 beats; tuser=1; error_runt=1; error_bad_fcs=0; frame_len=40.
- 1600-byte frame, MAX_FRAME_LEN=1518 -> exactly 1515 beats; tuser=1 on the last; error_oversize=1; frame_len=1519; nothing more until dv falls and the next SFD.
- gmii_rx_er on payload byte 10 -> tlast on byte 10 with tuser=1; frame_len=10; the next good frame passes.
- clk_enable toggling 1/0 every cycle with a good frame -> identical beat sequence at half rate; with GMII_RX_STATS_EN, stat_frames_good=1 and stat_frames_bad=0.

Source files
------------

// File: rtl/axis_gmii_rx_lenchk.sv
// rtl/axis_gmii_rx_lenchk.sv - GMII RX to AXI-Stream with SFD strip, FCS check and length policing
// Optional good/bad frame counters are built when GMII_RX_STATS_EN is defined.
module axis_gmii_rx_lenchk #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           gmii_rxd,
  input  logic                 gmii_rx_dv,
  input  logic                 gmii_rx_er,
  input  logic                 clk_enable,
  input  logic                 cfg_rx_enable,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 start_packet,
  output logic                 error_bad_frame,
  output logic                 error_bad_fcs,
  output logic                 error_runt,
  output logic                 error_oversize,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 frame_len_valid
`ifdef GMII_RX_STATS_EN
  ,
  output logic [31:0]          stat_frames_good,
  output logic [31:0]          stat_frames_bad
`endif
);

  localparam logic [7:0]           SFD     = 8'hD5;
  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_FRAME_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_LEN);
  localparam logic [LEN_WIDTH-1:0] OVR_LEN = LEN_WIDTH'(MAX_FRAME_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_WAIT_LAST} state_t;

  state_t               state_q, state_n;
  logic [4:0][7:0]      d_q;
  logic [4:0]           dv_q, er_q;
  logic                 dv_d1, dv_d4;
  logic [31:0]          crc_q, crc_n, crc_upd;
  logic [LEN_WIDTH-1:0] count_q, count_n, len_hdr, len_eop, len_n;
  logic                 fcs_bad, is_runt, clear_pipe;
  logic                 tvalid_n, tlast_n, tuser_n, sp_n, len_valid_n;
  logic                 bad_frame_n, bad_fcs_n, runt_n, oversize_n;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign dv_d1   = dv_q[1] & gmii_rx_dv;
  assign dv_d4   = dv_q[4] & gmii_rx_dv;
  assign crc_upd = crc32_byte(crc_q, d_q[4]);
  // d3 holds the first FCS byte on the wire, i.e. the low byte of the inverted CRC
  assign fcs_bad = (~crc_upd != {d_q[0], d_q[1], d_q[2], d_q[3]});
  assign len_hdr = count_q + LEN_WIDTH'(1);
  assign len_eop = count_q + LEN_WIDTH'(5);
  assign is_runt = (len_eop < MIN_LEN);

  always_comb begin
    state_n     = state_q;
    crc_n       = crc_q;
    count_n     = count_q;
    tvalid_n    = 1'b0;
    tlast_n     = 1'b0;
    tuser_n     = 1'b0;
    sp_n        = 1'b0;
    bad_frame_n = 1'b0;
    bad_fcs_n   = 1'b0;
    runt_n      = 1'b0;
    oversize_n  = 1'b0;
    len_valid_n = 1'b0;
    len_n       = frame_len;
    clear_pipe  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        crc_n   = 32'hFFFF_FFFF;
        count_n = '0;
        sp_n    = dv_d1 && !er_q[1] && (d_q[1] == SFD) && cfg_rx_enable;
        if (dv_d4 && !er_q[4] && (d_q[4] == SFD) && cfg_rx_enable) begin
          state_n = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        tvalid_n = 1'b1;
        if (er_q[4] && dv_d4) begin
          tlast_n     = 1'b1;
          tuser_n     = 1'b1;
          bad_frame_n = 1'b1;
          len_n       = len_hdr;
          len_valid_n = 1'b1;
          state_n     = S_WAIT_LAST;
        end else if (!gmii_rx_dv) begin
          tlast_n     = 1'b1;
          tuser_n     = (|er_q[3:0]) || fcs_bad || is_runt;
          bad_frame_n = tuser_n;
          bad_fcs_n   = fcs_bad;
          runt_n      = is_runt;
          len_n       = len_eop;
          len_valid_n = 1'b1;
          clear_pipe  = 1'b1;
          state_n     = S_IDLE;
        end else if (len_eop > MAX_LEN) begin
          tlast_n     = 1'b1;
          tuser_n     = 1'b1;
          bad_frame_n = 1'b1;
          oversize_n  = 1'b1;
          len_n       = OVR_LEN;
          len_valid_n = 1'b1;
          state_n     = S_WAIT_LAST;
        end else begin
          crc_n   = crc_upd;
          count_n = count_q + LEN_WIDTH'(1);
        end
      end
      S_WAIT_LAST: begin
        if (!gmii_rx_dv) begin
          clear_pipe = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      d_q             <= '0;
      dv_q            <= '0;
      er_q            <= '0;
      crc_q           <= 32'hFFFF_FFFF;
      count_q         <= '0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      start_packet    <= 1'b0;
      error_bad_frame <= 1'b0;
      error_bad_fcs   <= 1'b0;
      error_runt      <= 1'b0;
      error_oversize  <= 1'b0;
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
    end else if (clk_enable) begin
      d_q  <= {d_q[3:0], gmii_rxd};
      er_q <= {er_q[3:0], gmii_rx_er};
      // drop the finished frame's trailing bytes so its FCS cannot alias an SFD
      dv_q <= clear_pipe ? {4'b0000, gmii_rx_dv} : {dv_q[3:0], gmii_rx_dv};
      state_q <= state_n;
      crc_q   <= crc_n;
      count_q <= count_n;
      if (tvalid_n) begin
        m_axis_tdata <= d_q[4];
      end
      m_axis_tvalid   <= tvalid_n;
      m_axis_tlast    <= tlast_n;
      m_axis_tuser    <= tuser_n;
      start_packet    <= sp_n;
      error_bad_frame <= bad_frame_n;
      error_bad_fcs   <= bad_fcs_n;
      error_runt      <= runt_n;
      error_oversize  <= oversize_n;
      frame_len       <= len_n;
      frame_len_valid <= len_valid_n;
    end else begin
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      start_packet    <= 1'b0;
      error_bad_frame <= 1'b0;
      error_bad_fcs   <= 1'b0;
      error_runt      <= 1'b0;
      error_oversize  <= 1'b0;
      frame_len_valid <= 1'b0;
    end
  end

`ifdef GMII_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_good <= '0;
      stat_frames_bad  <= '0;
    end else if (clk_enable && tlast_n) begin
      if (tuser_n) begin
        if (stat_frames_bad != 32'hFFFF_FFFF) stat_frames_bad <= stat_frames_bad + 32'd1;
      end else begin
        if (stat_frames_good != 32'hFFFF_FFFF) stat_frames_good <= stat_frames_good + 32'd1;
      end
    end
  end
`endif

endmodule
